hps_peak_scheduler: RTL



---
 rtl/hps_pkg.sv | 22 ++
 rtl/hps_bin_feeder.sv | 36 +++
 rtl/hps_peak_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/hps_pkg.sv
// Shared constants for the HPS peak scheduler: FSM encoding, frame-size helpers and defaults.
// No logic, so there is no latency and no backpressure.
package hps_pkg;
    localparam int MAG_WIDTH_DEF = 96;
    localparam int K_WIDTH_DEF   = 11;
    localparam int MIN_BIN_DEF   = 1;
    localparam int N_BINS        = 1 << K_WIDTH_DEF;
    localparam int LAST_K        = N_BINS - 1;

    typedef logic [2:0] hps_state_t;

    localparam hps_state_t ST_IDLE  = 3'd0;
    localparam hps_state_t ST_CLEAR = 3'd1;
    localparam hps_state_t ST_SCAN  = 3'd2;
    localparam hps_state_t ST_DRAIN = 3'd3;
    localparam hps_state_t ST_WAIT  = 3'd4;
    localparam hps_state_t ST_HOLD  = 3'd5;

    function automatic int unsigned last_bin(input int unsigned k_width);
        return (32'd1 << k_width) - 32'd1;
    endfunction
endpackage

// File: rtl/hps_bin_feeder.sv
// Aligns RAM read enable/address with the read data and zeroes the excluded low bins.
// Latency: 1 cycle from rd_en/rd_addr to trk_valid/trk_k. Backpressure: none, the tracker always accepts.
module hps_bin_feeder #(
    parameter int MAG_WIDTH = 96,
    parameter int K_WIDTH   = 11,
    parameter int MIN_BIN   = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rd_en,
    input  logic [K_WIDTH-1:0]   rd_addr,
    input  logic [MAG_WIDTH-1:0] rd_data,
    output logic                 trk_valid,
    output logic [MAG_WIDTH-1:0] trk_data,
    output logic [K_WIDTH-1:0]   trk_k
);
    localparam logic [K_WIDTH:0] MIN_BIN_EXT = (K_WIDTH+1)'(MIN_BIN);

    logic               vld_q;
    logic [K_WIDTH-1:0] k_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            k_q   <= '0;
        end else begin
            vld_q <= rd_en;
            k_q   <= rd_en ? rd_addr : '0;
        end
    end

    // rd_data is the RAM's own output register; the select comes from flops, so this mux adds no path.
    assign trk_valid = vld_q;
    assign trk_k     = k_q;
    assign trk_data  = (vld_q && ({1'b0, k_q} >= MIN_BIN_EXT)) ? rd_data : '0;
endmodule

// File: rtl/hps_peak_scheduler.sv
// Per-frame HPS peak-search sequencer; HPS_OVERRUN_CNT_EN adds overrun/overrun_count outputs.
// Latency: frame_start to peak_valid is N+4 cycles. Backpressure: peak_valid/peak_k hold until peak_ready.
module hps_peak_scheduler
    import hps_pkg::*;
#(
    parameter int MAG_WIDTH = MAG_WIDTH_DEF,
    parameter int K_WIDTH   = K_WIDTH_DEF,
    parameter int MIN_BIN   = MIN_BIN_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_start,
    output logic                 ram_rd_en,
    output logic [K_WIDTH-1:0]   ram_rd_addr,
    input  logic [MAG_WIDTH-1:0] ram_rd_data,
    output logic                 trk_reset_n,
    output logic                 trk_valid,
    output logic [MAG_WIDTH-1:0] trk_data,
    output logic [K_WIDTH-1:0]   trk_k,
    input  logic [K_WIDTH-1:0]   trk_max_k,
    input  logic                 trk_max_k_valid,
    output logic [K_WIDTH-1:0]   peak_k,
    output logic                 peak_valid,
    input  logic                 peak_ready,
    output logic                 busy
`ifdef HPS_OVERRUN_CNT_EN
    ,
    output logic [15:0]          overrun_count,
    output logic                 overrun
`endif
);
    localparam logic [K_WIDTH-1:0] LAST_ADDR = K_WIDTH'(last_bin(K_WIDTH));

    hps_state_t state;
    hps_state_t state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (frame_start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_SCAN;
            ST_SCAN:  if (ram_rd_addr == LAST_ADDR) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_WAIT;
            ST_WAIT:  if (trk_max_k_valid) state_nxt = ST_HOLD;
            ST_HOLD:  if (peak_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            trk_reset_n <= 1'b0;
            peak_k      <= '0;
            peak_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != ST_IDLE);
            trk_reset_n <= (state_nxt != ST_CLEAR);
            ram_rd_en   <= (state_nxt == ST_SCAN);
            if (state == ST_SCAN && state_nxt == ST_SCAN)
                ram_rd_addr <= ram_rd_addr + 1'b1;
            else
                ram_rd_addr <= '0;
            if (state == ST_WAIT && trk_max_k_valid) begin
                peak_k     <= trk_max_k;
                peak_valid <= 1'b1;
            end else if (state == ST_HOLD && peak_ready) begin
                peak_valid <= 1'b0;
            end
        end
    end

    hps_bin_feeder #(
        .MAG_WIDTH (MAG_WIDTH),
        .K_WIDTH   (K_WIDTH),
        .MIN_BIN   (MIN_BIN)
    ) u_feeder (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_en     (ram_rd_en),
        .rd_addr   (ram_rd_addr),
        .rd_data   (ram_rd_data),
        .trk_valid (trk_valid),
        .trk_data  (trk_data),
        .trk_k     (trk_k)
    );

`ifdef HPS_OVERRUN_CNT_EN
    // A start seen while busy (including the HOLD/accept cycle) is dropped and flagged in the same cycle.
    assign overrun = frame_start && busy;

    always_ff @(posedge clock) begin
        if (!reset_n)
            overrun_count <= '0;
        else if (overrun && overrun_count != 16'hFFFF)
            overrun_count <= overrun_count + 16'd1;
    end
`endif
endmodule
